uart_tx_arbiter: RTL and testbench

Frame-atomic round-robin arbiter that shares the single UART transmit FIFO write port (`w_data`/`wr_uart`, back-pressured by `tx_full`) among several byte-stream requesters: the card encoder, the dealer-finished notifier and future message sources. It sits between those sources and the `uart` instance in the top level. A granted frame is sent contiguously and never interleaved with another requester's bytes.

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX frame arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CSUM = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 3;
    localparam int DEF_LEN_W      = 4;
    localparam int DEF_GAP_CYCLES = 2;

    localparam logic [7:0] CSUM_SEED = 8'h00;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic          valid,
    output logic [PW-1:0] winner
);

    int idx;

    // Walk offsets from far to near so the nearest requester overwrites the rest.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N;
            if (req[idx]) begin
                valid  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic round-robin arbiter in front of the UART TX FIFO write port.
// Optional trailing XOR checksum byte: define UART_ARB_CHECKSUM_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]    req_len,
    input  logic [NUM_REQ-1:0][7:0]          req_data,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic [NUM_REQ-1:0]               req_done,
    input  logic                             tx_full,
    output logic                             wr_uart,
    output logic [7:0]                       w_data,
    output logic                             busy,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [GW-1:0]     gap_q, gap_d;
`ifdef UART_ARB_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              pick_valid;
    logic [IW-1:0]     pick_winner;
    logic              frame_end;

    rr_pick #(.N(NUM_REQ), .PW(IW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            len_q    <= '0;
            gap_q    <= '0;
`ifdef UART_ARB_CHECKSUM_EN
            csum_q   <= CSUM_SEED;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            len_q    <= len_d;
            gap_q    <= gap_d;
`ifdef UART_ARB_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        len_d     = len_q;
        gap_d     = gap_q;
`ifdef UART_ARB_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        frame_end = 1'b0;
        wr_uart   = 1'b0;
        w_data    = 8'h00;
        req_ack   = '0;
        req_done  = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d  = pick_winner;
                    len_d    = req_len[pick_winner];
                    rr_ptr_d = (pick_winner == IW'(NUM_REQ - 1)) ? '0 : pick_winner + IW'(1);
`ifdef UART_ARB_CHECKSUM_EN
                    csum_d   = CSUM_SEED;
`endif
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                w_data = req_data[grant_q];
                if (len_q == '0) begin
                    // Empty frame: nothing to write and no checksum either.
                    req_done[grant_q] = 1'b1;
                    frame_end         = 1'b1;
                end else if (!tx_full) begin
                    wr_uart          = 1'b1;
                    req_ack[grant_q] = 1'b1;
                    len_d            = len_q - LEN_W'(1);
`ifdef UART_ARB_CHECKSUM_EN
                    csum_d           = csum_q ^ req_data[grant_q];
                    if (len_q == LEN_W'(1))
                        state_d = ST_CSUM;
`else
                    if (len_q == LEN_W'(1)) begin
                        req_done[grant_q] = 1'b1;
                        frame_end         = 1'b1;
                    end
`endif
                end
            end
`ifdef UART_ARB_CHECKSUM_EN
            ST_CSUM: begin
                w_data = csum_q;
                if (!tx_full) begin
                    wr_uart           = 1'b1;
                    req_done[grant_q] = 1'b1;
                    frame_end         = 1'b1;
                end
            end
`endif
            ST_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_end) begin
            gap_d = '0;
            if (GAP_CYCLES == 0)
                state_d = ST_IDLE;
            else
                state_d = ST_GAP;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (default parameters).
module tb_uart_tx_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req;
    logic [2:0][3:0]  req_len;
    logic [2:0][7:0]  req_data;
    logic [2:0]       req_ack;
    logic [2:0]       req_done;
    logic             tx_full;
    logic             wr_uart;
    logic [7:0]       w_data;
    logic             busy;
    logic [1:0]       grant_id;

    logic [7:0] mem [3][16];
    logic [3:0] ptr [3];
    logic       ptr_clr;

    int tests = 0;
    int fails = 0;

    uart_tx_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_len  (req_len),
        .req_data (req_data),
        .req_ack  (req_ack),
        .req_done (req_done),
        .tx_full  (tx_full),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    // Requester model: each source advances to its next byte after an ack.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ptr_clr)         ptr[i] <= 4'd0;
            else if (req_ack[i]) ptr[i] <= ptr[i] + 4'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) req_data[i] = mem[i][ptr[i]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ptr_clr = 1'b1; req = '0; tx_full = 1'b0; req_len = '0;
        step();
        rst = 1'b0; ptr_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ptr_clr = 1'b1; req = 3'b111; tx_full = 1'b0;
        req_len = {4'd1, 4'd1, 4'd1};
        step(); step();
        #1;
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %0h want 0", busy); end
        tests++; if (wr_uart !== 1'b0)  begin fails++; $display("FAIL reset_wr: got %0h want 0", wr_uart); end
        tests++; if (w_data !== 8'h00)  begin fails++; $display("FAIL reset_wdata: got %0h want 0", w_data); end
        tests++; if (req_ack !== 3'b0)  begin fails++; $display("FAIL reset_ack: got %0h want 0", req_ack); end
        tests++; if (req_done !== 3'b0) begin fails++; $display("FAIL reset_done: got %0h want 0", req_done); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0h want 0", grant_id); end
        rst = 1'b0; ptr_clr = 1'b0; req = '0;
        step();
    endtask

    task automatic test_single();
`ifdef UART_ARB_CHECKSUM_EN
        logic       ew [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
        logic [2:0] edn[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        logic       eb [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
`else
        logic       ew [8] = '{0, 1, 1, 1, 0, 0, 0, 0};
        logic [2:0] edn[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        logic       eb [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
`endif
        logic [7:0] ed [8] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [2:0] ea [8] = '{0, 1, 1, 1, 0, 0, 0, 0};
        do_reset();
        mem[0][0] = 8'h10; mem[0][1] = 8'h20; mem[0][2] = 8'h30;
        for (int c = 0; c < 8; c++) begin
            req = (c == 0) ? 3'b001 : 3'b000;
            req_len[0] = 4'd3;
            #1;
            tests++; if (wr_uart !== ew[c])  begin fails++; $display("FAIL single_wr c%0d: got %0h want %0h", c, wr_uart, ew[c]); end
            tests++; if (w_data !== ed[c])   begin fails++; $display("FAIL single_data c%0d: got %0h want %0h", c, w_data, ed[c]); end
            tests++; if (req_ack !== ea[c])  begin fails++; $display("FAIL single_ack c%0d: got %0h want %0h", c, req_ack, ea[c]); end
            tests++; if (req_done !== edn[c]) begin fails++; $display("FAIL single_done c%0d: got %0h want %0h", c, req_done, edn[c]); end
            tests++; if (busy !== eb[c])     begin fails++; $display("FAIL single_busy c%0d: got %0h want %0h", c, busy, eb[c]); end
            step();
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] eg [6] = '{0, 1, 2, 0, 1, 2};
        logic [7:0] ed [6] = '{8'h00, 8'h10, 8'h20, 8'h01, 8'h11, 8'h21};
        int n = 0;
        do_reset();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 16; k++) mem[i][k] = {i[3:0], k[3:0]};
        req = 3'b111;
        req_len = {4'd1, 4'd1, 4'd1};
        for (int c = 0; c < 60 && n < 6; c++) begin
            #1;
            if (req_ack != 3'b000) begin
                tests++; if (grant_id !== eg[n]) begin fails++; $display("FAIL rr_grant f%0d: got %0h want %0h", n, grant_id, eg[n]); end
                tests++; if (w_data !== ed[n])   begin fails++; $display("FAIL rr_data f%0d: got %0h want %0h", n, w_data, ed[n]); end
                n++;
            end
            step();
        end
        tests++; if (n != 6) begin fails++; $display("FAIL rr_timeout: got %0d frames want 6", n); end
        req = '0;
    endtask

    task automatic test_stall();
        logic       tf [11] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        logic [2:0] ea [11] = '{0, 4, 0, 0, 0, 0, 0, 4, 4, 4, 0};
`ifdef UART_ARB_CHECKSUM_EN
        logic       ew [11] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        logic [7:0] ed [11] = '{8'h00, 8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA3, 8'hA4, 8'h04};
        logic [2:0] edn[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4};
`else
        logic       ew [11] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        logic [7:0] ed [11] = '{8'h00, 8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA3, 8'hA4, 8'h00};
        logic [2:0] edn[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0};
`endif
        do_reset();
        mem[2][0] = 8'hA1; mem[2][1] = 8'hA2; mem[2][2] = 8'hA3; mem[2][3] = 8'hA4;
        req_len[2] = 4'd4;
        for (int c = 0; c < 11; c++) begin
            req = (c == 0) ? 3'b100 : 3'b000;
            tx_full = tf[c];
            #1;
            tests++; if (wr_uart !== ew[c])   begin fails++; $display("FAIL stall_wr c%0d: got %0h want %0h", c, wr_uart, ew[c]); end
            tests++; if (w_data !== ed[c])    begin fails++; $display("FAIL stall_data c%0d: got %0h want %0h", c, w_data, ed[c]); end
            tests++; if (req_ack !== ea[c])   begin fails++; $display("FAIL stall_ack c%0d: got %0h want %0h", c, req_ack, ea[c]); end
            tests++; if (req_done !== edn[c]) begin fails++; $display("FAIL stall_done c%0d: got %0h want %0h", c, req_done, edn[c]); end
            step();
        end
        tx_full = 1'b0;
    endtask

    task automatic test_len_zero();
        logic [2:0] edn[5] = '{0, 2, 0, 0, 0};
        logic       eb [5] = '{0, 1, 1, 1, 0};
        do_reset();
        req_len[1] = 4'd0;
        for (int c = 0; c < 5; c++) begin
            req = (c == 0) ? 3'b010 : 3'b000;
            #1;
            tests++; if (wr_uart !== 1'b0)    begin fails++; $display("FAIL len0_wr c%0d: got %0h want 0", c, wr_uart); end
            tests++; if (req_done !== edn[c]) begin fails++; $display("FAIL len0_done c%0d: got %0h want %0h", c, req_done, edn[c]); end
            tests++; if (busy !== eb[c])      begin fails++; $display("FAIL len0_busy c%0d: got %0h want %0h", c, busy, eb[c]); end
            if (c == 1) begin
                tests++; if (grant_id !== 2'd1) begin fails++; $display("FAIL len0_grant: got %0h want 1", grant_id); end
            end
            step();
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        mem[1][0] = 8'hB1; mem[1][1] = 8'hB2; mem[1][2] = 8'hB3; mem[1][3] = 8'hB4;
        mem[0][0] = 8'hC0;
        req = 3'b010; req_len[1] = 4'd4;
        step();
        req = 3'b000;
        #1;
        tests++; if (w_data !== 8'hB1) begin fails++; $display("FAIL rstmid_b1: got %0h want b1", w_data); end
        step();
        rst = 1'b1;
        #1;
        tests++; if (w_data !== 8'hB2)    begin fails++; $display("FAIL rstmid_b2: got %0h want b2", w_data); end
        tests++; if (req_done !== 3'b000) begin fails++; $display("FAIL rstmid_done: got %0h want 0", req_done); end
        step();
        rst = 1'b0;
        req = 3'b111; req_len = {4'd1, 4'd1, 4'd1};
        #1;
        tests++; if (wr_uart !== 1'b0)    begin fails++; $display("FAIL rstmid_wr_after: got %0h want 0", wr_uart); end
        tests++; if (req_done !== 3'b000) begin fails++; $display("FAIL rstmid_done_after: got %0h want 0", req_done); end
        tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL rstmid_busy: got %0h want 0", busy); end
        step();
        req = 3'b000;
        #1;
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rstmid_next_grant: got %0h want 0", grant_id); end
        tests++; if (wr_uart !== 1'b1)  begin fails++; $display("FAIL rstmid_next_wr: got %0h want 1", wr_uart); end
        tests++; if (w_data !== 8'hC0)  begin fails++; $display("FAIL rstmid_next_data: got %0h want c0", w_data); end
        step();
    endtask

`ifdef UART_ARB_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        mem[0][0] = 8'h5A; mem[0][1] = 8'h0F;
        req = 3'b001; req_len[0] = 4'd2;
        step();
        req = 3'b000;
        #1;
        tests++; if (w_data !== 8'h5A) begin fails++; $display("FAIL csum_b0: got %0h want 5a", w_data); end
        step();
        #1;
        tests++; if (w_data !== 8'h0F) begin fails++; $display("FAIL csum_b1: got %0h want 0f", w_data); end
        step();
        #1;
        tests++; if (wr_uart !== 1'b1)    begin fails++; $display("FAIL csum_wr: got %0h want 1", wr_uart); end
        tests++; if (w_data !== 8'h55)    begin fails++; $display("FAIL csum_data: got %0h want 55", w_data); end
        tests++; if (req_done !== 3'b001) begin fails++; $display("FAIL csum_done: got %0h want 1", req_done); end
        tests++; if (req_ack !== 3'b000)  begin fails++; $display("FAIL csum_ack: got %0h want 0", req_ack); end
        step();
    endtask
`endif

    initial begin
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 16; k++) mem[i][k] = 8'h00;
        rst = 1'b1; ptr_clr = 1'b1; req = '0; req_len = '0; tx_full = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_len_zero();
        test_reset_mid_frame();
`ifdef UART_ARB_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
